// File: rtl/display_pkg.sv
// Shared 7-segment encoding for the board's common-anode displays.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}: bit 0 drives segment a.
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam seg_t SEG_OFF = 7'h7F;

    // Wide enough for any digit count a scan driver can address; users take the low bits.
    localparam logic [31:0] ANODES_OFF = '1;

    localparam seg_t HEX_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    function automatic seg_t hex_encode(input logic [3:0] value);
        return HEX_TABLE[value];
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex-to-segment decoder, active-low {g..a}; shared by any display path.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_encode(hex);

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed scan controller for a common-anode 7-segment display:
// prescaler, digit index counter, anti-ghosting guard and registered outputs.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 4,
    parameter int DIGITS       = 8,
    parameter int width        = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [3:0]        nibble,
    input  logic [DIGITS-1:0] dp_mask,
    input  logic [DIGITS-1:0] blank_mask,
    output logic [width-1:0]  digit_sel,
    output logic [DIGITS-1:0] anodes,
    output logic [6:0]        segments,
    output logic              dp,
    output logic              digit_tick
);

    localparam int               PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [width-1:0] SEL_LAST = width'(DIGITS - 1);
    localparam int               SEL_SPAN = 2 ** width;

    logic [PRE_W-1:0]    pre;
    logic                terminal;
    logic                guard;
    logic                dark;
    logic [6:0]          hex_seg;
    logic [DIGITS-1:0]   sel_onehot;
    logic [SEL_SPAN-1:0] dp_ext;
    logic [SEL_SPAN-1:0] blank_ext;

    assign terminal   = enable && (pre == PRE_LAST);
    assign digit_tick = terminal;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre       <= '0;
            digit_sel <= '0;
        end else if (!enable) begin
            pre <= '0;
        end else if (terminal) begin
            pre       <= '0;
            digit_sel <= (digit_sel == SEL_LAST) ? '0 : digit_sel + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // The wrap cycle is blanked as well, so the outgoing digit goes dark on the
    // same edge that moves digit_sel; the guard then covers the new nibble settling.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_guard
            assign guard = 1'b0;
        end else begin : g_guard
            assign guard = (pre < PRE_W'(BLANK_CYCLES)) || terminal;
        end
    endgenerate

    // Masks padded to the full index span so any digit_sel value indexes safely.
    // NOTE: every always_comb output gets a default first, which rules out inferred latches.
    always_comb begin
        dp_ext                 = '0;
        blank_ext              = '0;
        dp_ext[DIGITS-1:0]     = dp_mask;
        blank_ext[DIGITS-1:0]  = blank_mask;
    end

    assign sel_onehot = DIGITS'(1) << digit_sel;
    assign dark       = !enable || guard || blank_ext[digit_sel];

    hex_to_7seg u_hex_to_7seg (
        .hex (nibble),
        .seg (hex_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodes   <= ANODES_OFF[DIGITS-1:0];
            segments <= SEG_OFF;
            dp       <= 1'b1;
        end else if (dark) begin
            anodes   <= ANODES_OFF[DIGITS-1:0];
            segments <= SEG_OFF;
            dp       <= 1'b1;
        end else begin
            anodes   <= ~sel_onehot;
            segments <= hex_seg;
            dp       <= ~dp_ext[digit_sel];
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver: cycle model + output scoreboard.
module tb_display_scan_driver;

    localparam logic [31:0] DISP_VALUE = 32'h0123_4567;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    logic clk;
    logic rst_n, six_rst_n, hx_rst_n;
    logic enable;
    logic [7:0] dp_mask, blank_mask;

    logic [3:0] nibble;
    logic [2:0] digit_sel;
    logic [7:0] anodes;
    logic [6:0] segments;
    logic       dp, digit_tick;

    logic [3:0] six_nibble;
    logic [2:0] six_sel;
    logic [5:0] six_anodes;
    logic [6:0] six_segments;
    logic       six_dp, six_tick;

    logic [3:0] hx_nibble;
    logic [2:0] hx_sel;
    logic [7:0] hx_anodes;
    logic [6:0] hx_segments;
    logic       hx_dp, hx_tick;

    int n_checks = 0;
    int n_errors = 0;
    int m_pre, m_sel, s_pre, s_sel;
    out_t       sb[$];
    logic [6:0] seg_sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Selector model: digit 0 is the low nibble of the displayed value.
    assign nibble     = 4'(DISP_VALUE >> (4 * digit_sel));
    assign six_nibble = 4'(DISP_VALUE >> (4 * six_sel));

    display_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .DIGITS(8), .width(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .nibble(nibble),
        .dp_mask(dp_mask), .blank_mask(blank_mask), .digit_sel(digit_sel),
        .anodes(anodes), .segments(segments), .dp(dp), .digit_tick(digit_tick)
    );

    display_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .DIGITS(6), .width(3)) u_six (
        .clk(clk), .rst_n(six_rst_n), .enable(enable), .nibble(six_nibble),
        .dp_mask(6'h00), .blank_mask(6'h00), .digit_sel(six_sel),
        .anodes(six_anodes), .segments(six_segments), .dp(six_dp), .digit_tick(six_tick)
    );

    display_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(0), .DIGITS(8), .width(3)) u_hex (
        .clk(clk), .rst_n(hx_rst_n), .enable(enable), .nibble(hx_nibble),
        .dp_mask(8'h00), .blank_mask(8'h00), .digit_sel(hx_sel),
        .anodes(hx_anodes), .segments(hx_segments), .dp(hx_dp), .digit_tick(hx_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] hex_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            4'hF: return 7'b0001110;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected registered output for the state seen before an edge.
    function automatic out_t model_out(input int div, input int blank, input int pre,
                                       input int sel, input int digits, input logic en,
                                       input logic [7:0] bm, input logic [7:0] dm);
        out_t o;
        logic [7:0] all_off;
        logic [3:0] nib;
        all_off = 8'hFF >> (8 - digits);
        nib     = 4'(DISP_VALUE >> (4 * sel));
        o.an    = all_off;
        o.seg   = 7'h7F;
        o.dp    = 1'b1;
        if (en && !bm[sel] && !(blank > 0 && (pre < blank || pre == div - 1))) begin
            o.an  = all_off & ~(8'd1 << sel);
            o.seg = hex_ref(nib);
            o.dp  = ~dm[sel];
        end
        return o;
    endfunction

    task automatic step_main();
        out_t exp;
        sb.push_back(model_out(8, 2, m_pre, m_sel, 8, enable, blank_mask, dp_mask));
        check("tick", digit_tick, 32'(enable && m_pre == 7));
        check("sel", digit_sel, m_sel);
        if (!enable) m_pre = 0;
        else if (m_pre == 7) begin
            m_pre = 0;
            m_sel = (m_sel + 1) % 8;
        end else m_pre++;
        @(posedge clk); #1;
        exp = sb.pop_front();
        check("anodes", anodes, exp.an);
        check("segments", segments, exp.seg);
        check("dp", dp, exp.dp);
    endtask

    task automatic step_six();
        out_t exp;
        logic [5:0] a;
        sb.push_back(model_out(4, 2, s_pre, s_sel, 6, enable, 8'h00, 8'h00));
        check("six_sel", six_sel, s_sel);
        check("six_tick", six_tick, 32'(enable && s_pre == 3));
        if (s_pre == 3) begin
            s_pre = 0;
            s_sel = (s_sel + 1) % 6;
        end else s_pre++;
        @(posedge clk); #1;
        exp = sb.pop_front();
        a   = six_anodes;
        check("six_anodes", six_anodes, exp.an);
        check("six_an_set", 32'(a == 6'h3F || $onehot(~a)), 1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit0, ticks, last_tick, dp_lo, lit2, wraps;
        logic [2:0] prev_sel;

        rst_n = 1'b0; six_rst_n = 1'b0; hx_rst_n = 1'b0;
        enable = 1'b1; dp_mask = 8'h00; blank_mask = 8'h00; hx_nibble = 4'h0;
        #12;
        check("rst_anodes", anodes, 8'hFF);
        check("rst_segments", segments, 7'h7F);
        check("rst_dp", dp, 1);
        check("rst_sel", digit_sel, 0);
        check("rst_tick", digit_tick, 0);

        @(posedge clk); #1;
        rst_n = 1'b1; m_pre = 0; m_sel = 0;

        // Reset mid-scan, while digit 5 is lit.
        repeat (44) step_main();
        check("pre_rst_sel", digit_sel, 5);
        check("pre_rst_anodes", anodes, 8'hDF);
        #2 rst_n = 1'b0;
        #1;
        check("async_anodes", anodes, 8'hFF);
        check("async_segments", segments, 7'h7F);
        check("async_dp", dp, 1);
        check("async_sel", digit_sel, 0);
        check("async_tick", digit_tick, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; m_pre = 0; m_sel = 0; sb.delete();
        check("post_rst_sel", digit_sel, 0);

        // Full sweep.
        lit0 = 0; ticks = 0; last_tick = -1;
        for (int n = 1; n <= 64; n++) begin
            if (digit_tick) begin
                ticks++;
                if (last_tick >= 0) check("tick_period", n - last_tick, 8);
                last_tick = n;
            end
            step_main();
            if (anodes == 8'hFE) begin
                lit0++;
                check("seg_digit0", segments, 7'b1111000);
            end
            if (anodes == 8'h7F) check("seg_digit7", segments, 7'b1000000);
        end
        check("lit_digit0", lit0, 5);
        check("tick_count", ticks, 8);

        // Masks.
        blank_mask = 8'h04; dp_mask = 8'h01;
        dp_lo = 0; lit2 = 0;
        repeat (64) begin
            step_main();
            if (anodes == 8'hFB) lit2++;
            if (dp == 1'b0) begin
                dp_lo++;
                check("dp_only_digit0", anodes, 8'hFE);
            end
        end
        check("digit2_lit_cycles", lit2, 0);
        check("dp_low_cycles", dp_lo, 5);
        blank_mask = 8'h00; dp_mask = 8'h00;

        // Enable toggle while digit 3 is scanned.
        repeat (28) step_main();
        check("pre_dis_sel", digit_sel, 3);
        enable = 1'b0;
        step_main();
        check("dis_dark", anodes, 8'hFF);
        repeat (5) begin
            check("dis_tick", digit_tick, 0);
            check("dis_sel", digit_sel, 3);
            step_main();
        end
        enable = 1'b1;
        check("reen_dark0", anodes, 8'hFF);
        step_main();
        check("reen_dark1", anodes, 8'hFF);
        step_main();
        check("reen_dark2", anodes, 8'hFF);
        step_main();
        check("reen_lit", anodes, 8'hF7);
        sb.delete();

        // Non-power-of-2 digit count.
        six_rst_n = 1'b1; s_pre = 0; s_sel = 0;
        wraps = 0; prev_sel = six_sel;
        repeat (48) begin
            step_six();
            if (prev_sel == 3'd5 && six_sel == 3'd0) wraps++;
            prev_sel = six_sel;
        end
        check("six_wraps", wraps, 2);
        sb.delete();

        // Hex table with the guard disabled.
        hx_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            hx_nibble = 4'(i);
            seg_sb.push_back(hex_ref(4'(i)));
            @(posedge clk); #1;
            check($sformatf("hex_%0h", i), hx_segments, seg_sb.pop_front());
            check($sformatf("hex_an_%0h", i), hx_anodes, (i < 8) ? 8'hFE : 8'hFD);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
